// File: rtl/kgs_multiword_adder.sv
// Multi-precision add/subtract engine: streams word pairs LS-word first through a
// Kogge-Stone core, chaining a registered carry between words of one operation.
module kgs #(
  parameter int size = 32
) (
  input  logic [size-2:0] a,
  input  logic [size-2:0] b,
  input  logic            cin,
  output logic [size-2:0] sum,
  output logic            cout
);
  localparam int N  = size - 1;
  localparam int LV = (N > 1) ? $clog2(N) : 0;

  logic [LV:0][N-1:0] gl;
  logic [LV:0][N-1:0] pl;
  logic [N:0]         c;

  assign gl[0] = a & b;
  assign pl[0] = a ^ b;

  genvar gk, gi;
  generate
    for (gk = 0; gk < LV; gk++) begin : g_level
      for (gi = 0; gi < N; gi++) begin : g_bit
        if (gi >= (1 << gk)) begin : g_merge
          assign gl[gk+1][gi] = gl[gk][gi] | (pl[gk][gi] & gl[gk][gi-(1<<gk)]);
          assign pl[gk+1][gi] = pl[gk][gi] & pl[gk][gi-(1<<gk)];
        end else begin : g_pass
          assign gl[gk+1][gi] = gl[gk][gi];
          assign pl[gk+1][gi] = pl[gk][gi];
        end
      end
    end

    // cin folds in after the prefix tree: group propagate over [i:0] passes it up.
    assign c[0] = cin;
    for (gi = 0; gi < N; gi++) begin : g_carry
      assign c[gi+1] = gl[LV][gi] | (pl[LV][gi] & cin);
      assign sum[gi] = pl[0][gi] ^ c[gi];
    end
  endgenerate

  assign cout = c[N];
endmodule

module kgs_multiword_adder #(
  parameter int WIDTH = 31,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_first,
  input  logic             in_last,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_last,
  output logic [CNT_W-1:0] out_idx,
  output logic             err
);
  localparam logic IDLE = 1'b0;
  localparam logic BUSY = 1'b1;

  logic             state_q;
  logic             carry_q;
  logic             mode_q;
  logic [CNT_W-1:0] idx_q;

  logic             accept;
  logic             first_eff;
  logic             sub;
  logic [WIDTH-1:0] b_eff;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic [CNT_W-1:0] idx_next;
  logic             proto_err;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // A non-first beat arriving in IDLE is still treated as the start of an operation.
  always_comb begin
    first_eff = (state_q == IDLE) || in_first;
    sub       = first_eff ? in_sub : mode_q;
    b_eff     = sub ? ~in_b : in_b;
    cin       = first_eff ? sub : carry_q;
    idx_next  = first_eff ? '0 : idx_q;
    proto_err = ((state_q == IDLE) && !in_first) || ((state_q == BUSY) && in_first);
  end

  kgs #(.size(WIDTH + 1)) u_core (
    .a    (in_a),
    .b    (b_eff),
    .cin  (cin),
    .sum  (sum),
    .cout (cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_carry <= 1'b0;
      out_last  <= 1'b0;
      out_idx   <= '0;
      err       <= 1'b0;
      carry_q   <= 1'b0;
      mode_q    <= 1'b0;
      idx_q     <= '0;
      state_q   <= IDLE;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_sum   <= sum;
        out_carry <= cout;
        out_last  <= in_last;
        out_idx   <= idx_next;
        carry_q   <= cout;
        mode_q    <= sub;
        idx_q     <= idx_next + CNT_W'(1);
        state_q   <= in_last ? IDLE : BUSY;
        if (proto_err) err <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_kgs_multiword_adder.sv
// Directed-vector bench for kgs_multiword_adder at WIDTH=8 with hand-computed results.
module tb_kgs_multiword_adder;
  localparam int WIDTH = 8;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_first;
  logic             in_last;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_carry;
  logic             out_last;
  logic [CNT_W-1:0] out_idx;
  logic             err;

  int total;
  int bad;
  logic [WIDTH-1:0] rx[$];

  kgs_multiword_adder #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_first  (in_first),
    .in_last   (in_last),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry),
    .out_last  (out_last),
    .out_idx   (out_idx),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (out_valid && out_ready) rx.push_back(out_sum);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b,
                       input logic f, input logic l, input logic s);
    in_a = a; in_b = b; in_first = f; in_last = l; in_sub = s;
    in_valid = 1'b1;
  endtask

  // Presents one beat, lets it be accepted on the next edge, then checks the output word.
  task automatic beat(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic f, input logic l, input logic s,
                      input logic [7:0] e_sum, input logic e_c, input logic e_l,
                      input logic [7:0] e_idx);
    drive(a, b, f, l, s);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".sum"},   32'(out_sum),   32'(e_sum));
    chk({tag, ".carry"}, 32'(out_carry), 32'(e_c));
    chk({tag, ".last"},  32'(out_last),  32'(e_l));
    chk({tag, ".idx"},   32'(out_idx),   32'(e_idx));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_first = 1'b0; in_last = 1'b0; in_sub = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.sum",   32'(out_sum),   32'd0);
    chk("rst.err",   32'(err),       32'd0);
    chk("rst.ready", 32'(in_ready),  32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    beat("single", 8'h7F, 8'h01, 1, 1, 0, 8'h80, 0, 1, 8'd0);

    beat("add3.w0", 8'hFF, 8'h01, 1, 0, 0, 8'h00, 1, 0, 8'd0);
    beat("add3.w1", 8'hFF, 8'h00, 0, 0, 0, 8'h00, 1, 0, 8'd1);
    beat("add3.w2", 8'h00, 8'h00, 0, 1, 0, 8'h01, 0, 1, 8'd2);

    beat("sub2.w0", 8'h00, 8'h01, 1, 0, 1, 8'hFF, 0, 0, 8'd0);
    beat("sub2.w1", 8'h01, 8'h00, 0, 1, 0, 8'h00, 1, 1, 8'd1);
    chk("clean.err", 32'(err), 32'd0);

    // Backpressure: output held for three cycles while the next beat waits.
    @(posedge clk); #1;
    rx.delete();
    out_ready = 1'b0;
    drive(8'h10, 8'h20, 1, 0, 0);
    @(posedge clk); #1;
    chk("bp.a.sum", 32'(out_sum), 32'h30);
    drive(8'h01, 8'h02, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bp.hold%0d.ready", i), 32'(in_ready), 32'd0);
      chk($sformatf("bp.hold%0d.sum", i),   32'(out_sum),  32'h30);
      chk($sformatf("bp.hold%0d.valid", i), 32'(out_valid), 32'd1);
      @(posedge clk); #1;
    end
    chk("bp.still.sum", 32'(out_sum), 32'h30);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp.b.sum", 32'(out_sum), 32'h03);
    chk("bp.b.idx", 32'(out_idx), 32'd1);
    drive(8'h05, 8'h06, 0, 1, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp.c.sum",  32'(out_sum),  32'h0B);
    chk("bp.c.idx",  32'(out_idx),  32'd2);
    chk("bp.c.last", 32'(out_last), 32'd1);
    @(posedge clk); #1;
    chk("bp.drained", 32'(out_valid), 32'd0);
    chk("bp.count", 32'(rx.size()), 32'd3);
    if (rx.size() == 3) begin
      chk("bp.rx0", 32'(rx[0]), 32'h30);
      chk("bp.rx1", 32'(rx[1]), 32'h03);
      chk("bp.rx2", 32'(rx[2]), 32'h0B);
    end

    // First word while busy restarts the operation and flags the error.
    beat("re.w0", 8'h01, 8'h01, 1, 0, 0, 8'h02, 0, 0, 8'd0);
    chk("re.pre.err", 32'(err), 32'd0);
    beat("re.new", 8'h03, 8'h04, 1, 0, 1, 8'hFF, 0, 0, 8'd0);
    chk("re.err", 32'(err), 32'd1);
    beat("re.w1", 8'h00, 8'h00, 0, 1, 0, 8'hFF, 0, 1, 8'd1);
    chk("re.sticky", 32'(err), 32'd1);

    // Asynchronous reset mid-operation.
    beat("ar.w0", 8'h11, 8'h22, 1, 0, 0, 8'h33, 0, 0, 8'd0);
    rst_n = 1'b0;
    #1;
    chk("ar.valid", 32'(out_valid), 32'd0);
    chk("ar.sum",   32'(out_sum),   32'd0);
    chk("ar.err",   32'(err),       32'd0);
    #2;
    rst_n = 1'b1;
    beat("ar.nofirst", 8'h05, 8'h03, 0, 1, 1, 8'h02, 1, 1, 8'd0);
    chk("ar.err.set", 32'(err), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
